periph_bus_fabric: RTL and testbench
====================================

# periph_bus_fabric

Parametrised peripheral bus fabric that connects the CPU subsystem's single peripheral port to `NUM_SLAVES` peripheral subsystems (GPIO, timers, UART, …) using the native valid/ready peripheral protocol. It decodes the address, forwards the request to exactly one slave, and returns that slave's response. It also produces an error response for unmapped addresses or for slaves that never respond. It sits in the SoC top between the CPU subsystem and the peripheral subsystems, and replaces the direct point-to-point peripheral connection.

## Interface
Parameters:
- `NUM_SLAVES`, 4: number of slave ports (1–16).
- `ADDR_W`, 31: peripheral address width.
- `SLAVE_BASE`, packed `NUM_SLAVES*ADDR_W`, all zeros: base address of slave i, held in slice i.
- `SLAVE_MASK`, packed `NUM_SLAVES*ADDR_W`, all zeros: slave i matches when `(m_addr & MASK_i) == BASE_i`.
- `TIMEOUT_CYCLES`, 255: maximum ACCESS cycles allowed (1–65535).
- `ERR_RDATA`, 32'hDEAD_BEEF: read data returned on any error.

Ports:
- `sys_clk`, in, 1: system clock.
- `rst_n`, in, 1: active-low reset, synchronous to `sys_clk`.
- `m_valid`, `m_write`, in, 1: master request and direction.
- `m_addr`, in, `ADDR_W`; `m_wdata`, in, 32; `m_wstrb`, in, 4: master request fields.
- `m_rdata`, out, 32; `m_ready`, out, 1; `m_err`, out, 1: master response.
- `s_valid`, out, `NUM_SLAVES`: one-hot request to the slaves.
- `s_addr`, out, `ADDR_W`; `s_write`, out, 1; `s_wdata`, out, 32; `s_wstrb`, out, 4: request fields, broadcast to all slaves.
- `s_rdata`, in, `NUM_SLAVES*32`; `s_ready`, in, `NUM_SLAVES`: slave responses.
- `err_clear`, in, 1: pulse that clears the error counter.
- `err_count`, out, 8: count of errors, saturating.
- `err_addr`, out, `ADDR_W`: address of the most recent error.
- `err_irq`, out, 1: one-cycle pulse per error.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - `m_valid` is sampled only in this state.
  - On `m_valid=1`, register `m_addr`, `m_write`, `m_wdata` and `m_wstrb` onto the `s_*` outputs.
  - Decode the address; when several slaves match, the lowest index wins.
  - Hit: store the index in `sel` and move to ACCESS.
  - No hit: set the pending error flag and move directly to RESP.
- ACCESS:
  - `s_valid[sel]=1`; all other `s_valid` bits are 0.
  - The timeout counter starts at 0 and increments every cycle.
  - `s_ready[sel]=1`: capture `s_rdata[sel]` and move to RESP with no error.
  - Counter reaches `TIMEOUT_CYCLES-1` with no ready: set the error flag and move to RESP. `s_valid` drops on entry to RESP.
  - `s_ready` bits of unselected slaves are ignored in every state.
  - A slave's late `s_ready` after a timeout is ignored.
- RESP:
  - Drive `m_ready=1` for exactly one cycle.
  - No error: `m_err=0`, `m_rdata` = captured data (also returned on writes).
  - Error: `m_err=1`, `m_rdata=ERR_RDATA`.
  - Always return to IDLE.
- Error bookkeeping happens on the RESP cycle of an error:
  - `err_irq=1`.
  - `err_addr` = address of the failing request.
  - `err_count` increments and saturates at 255.
- `err_clear` sets `err_count` to 0. If a clear and an error arrive in the same cycle, `err_count` becomes 1.
- If the master drops `m_valid` mid-transaction (a protocol violation), the transaction still completes normally.

## Timing
- Reset values: FSM in IDLE. `m_ready`, `m_err`, `err_irq`, `s_valid`, `s_write` and `s_wstrb` are 0. `m_rdata`, `s_addr`, `s_wdata`, `err_count` and `err_addr` are 0.
- Reset asserted mid-transaction: the fabric returns to IDLE at the next edge and no response is issued.
- Request sampled in cycle 0 (IDLE):
  - `s_valid` is high from cycle 1.
  - Slave ready in cycle k (k≥1) gives `m_ready` in cycle k+1.
  - Minimum latency is 2 cycles, for a slave that responds the same cycle it sees `s_valid`.
- Decode error: `m_ready` with `m_err` in cycle 1.
- Timeout: `s_valid` is high in cycles 1..`TIMEOUT_CYCLES`, and the error response comes in cycle `TIMEOUT_CYCLES+1`.
- The cycle after RESP is IDLE, so a back-to-back request is sampled at the earliest 1 cycle after `m_ready`.
- `m_rdata` holds its value outside RESP. `m_err` is valid only while `m_ready=1`.

## Test plan
- Slave 2 (base 0x100, mask 0x7FFFFF00) responds with ready 3 cycles after `s_valid`; read 0x104 -> `s_valid=4'b0100` for 3 cycles, `m_ready` in cycle 4, `m_rdata` = slave data, `m_err=0`.
- Write to 0x004 with wstrb 4'b0011; slave 0 readies immediately -> `s_wdata` and `s_wstrb` match the request, `m_ready` in cycle 2.
- Access to unmapped 0x7000_0000 -> `m_ready` and `m_err` in cycle 1, `m_rdata=DEADBEEF`, `err_count=1`, `err_addr=0x7000_0000`, one `err_irq` pulse.
- Slave never readies, `TIMEOUT_CYCLES=8` -> 8 cycles of `s_valid`, error response in cycle 9; a later slave ready pulse changes nothing.
- 300 decode errors -> `err_count` holds at 255; `err_clear` coincident with an error -> `err_count=1`.
- `rst_n` pulled low during ACCESS -> all outputs are 0 at the next edge, and a fresh read afterwards completes normally.

Source files
------------

// File: rtl/periph_bus_fabric.sv
// Peripheral bus fabric: one valid/ready master to NUM_SLAVES slaves with decode/timeout error responses.
// Latency: slave ready in cycle k gives m_ready in k+1 (min 2); one request in flight, m_valid only sampled in IDLE.
module periph_bus_fabric #(
  parameter int                          NUM_SLAVES     = 4,
  parameter int                          ADDR_W         = 31,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE     = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK     = '0,
  parameter int                          TIMEOUT_CYCLES = 255,
  parameter logic [31:0]                 ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic                       m_valid,
  input  logic                       m_write,
  input  logic [ADDR_W-1:0]          m_addr,
  input  logic [31:0]                m_wdata,
  input  logic [3:0]                 m_wstrb,
  output logic [31:0]                m_rdata,
  output logic                       m_ready,
  output logic                       m_err,
  output logic [NUM_SLAVES-1:0]      s_valid,
  output logic [ADDR_W-1:0]          s_addr,
  output logic                       s_write,
  output logic [31:0]                s_wdata,
  output logic [3:0]                 s_wstrb,
  input  logic [NUM_SLAVES*32-1:0]   s_rdata,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  input  logic                       err_clear,
  output logic [7:0]                 err_count,
  output logic [ADDR_W-1:0]          err_addr,
  output logic                       err_irq
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] w_dec_idx;
  logic             w_dec_hit;
  logic [15:0]      r_tmo_cnt;
  logic             r_err;
  logic             w_sel_rdy;
  logic [31:0]      w_sel_rdata;
  logic             w_tmo;
  logic             w_err_evt;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    w_dec_hit = 1'b0;
    w_dec_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
        w_dec_hit = 1'b1;
        w_dec_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    w_sel_rdy   = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_sel == SEL_W'(i)) begin
        w_sel_rdy   = s_ready[i];
        w_sel_rdata = s_rdata[i*32 +: 32];
      end
    end
  end

  assign w_tmo = (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge sys_clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_err_evt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (m_valid) begin
          w_next    = w_dec_hit ? ST_ACCESS : ST_RESP;
          w_err_evt = !w_dec_hit;
        end
      end
      ST_ACCESS: begin
        // A ready on the final allowed cycle still counts as a normal completion.
        if (w_sel_rdy) begin
          w_next = ST_RESP;
        end else if (w_tmo) begin
          w_next    = ST_RESP;
          w_err_evt = 1'b1;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s_valid = '0;
    if (r_state == ST_ACCESS) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        s_valid[i] = (r_sel == SEL_W'(i));
      end
    end
  end

  assign m_ready = (r_state == ST_RESP);
  assign m_err   = m_ready & r_err;
  assign err_irq = m_err;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_sel     <= '0;
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
      m_rdata   <= '0;
      s_addr    <= '0;
      s_write   <= 1'b0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      err_count <= '0;
      err_addr  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tmo_cnt <= '0;
          if (m_valid) begin
            s_addr  <= m_addr;
            s_write <= m_write;
            s_wdata <= m_wdata;
            s_wstrb <= m_wstrb;
            r_sel   <= w_dec_idx;
            r_err   <= !w_dec_hit;
            if (!w_dec_hit) m_rdata <= ERR_RDATA;
          end
        end
        ST_ACCESS: begin
          r_tmo_cnt <= r_tmo_cnt + 16'd1;
          if (w_sel_rdy) begin
            m_rdata <= w_sel_rdata;
            r_err   <= 1'b0;
          end else if (w_tmo) begin
            m_rdata <= ERR_RDATA;
            r_err   <= 1'b1;
          end
        end
        default: ;
      endcase

      // Bookkeeping lands on entry to RESP so it is visible alongside err_irq.
      if (w_err_evt) begin
        err_addr  <= (r_state == ST_IDLE) ? m_addr : s_addr;
        err_count <= err_clear ? 8'd1 : ((err_count == 8'hFF) ? 8'hFF : err_count + 8'd1);
      end else if (err_clear) begin
        err_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_periph_bus_fabric.sv
// Bench for periph_bus_fabric: vector table with a response scoreboard plus hand-written
// sequences for timeout, late ready, counter saturation/clear and mid-transaction reset.
module tb_periph_bus_fabric;

  localparam int NS   = 4;
  localparam int AW   = 31;
  localparam int TMO  = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic          sys_clk = 1'b0;
  logic          rst_n;
  logic          m_valid, m_write;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [3:0]    m_wstrb;
  logic [31:0]   m_rdata;
  logic          m_ready, m_err;
  logic [NS-1:0] s_valid;
  logic [AW-1:0] s_addr;
  logic          s_write;
  logic [31:0]   s_wdata;
  logic [3:0]    s_wstrb;
  logic [NS*32-1:0] s_rdata;
  logic [NS-1:0] s_ready;
  logic          err_clear;
  logic [7:0]    err_count;
  logic [AW-1:0] err_addr;
  logic          err_irq;

  always #5 sys_clk = ~sys_clk;

  periph_bus_fabric #(
    .NUM_SLAVES    (NS),
    .ADDR_W        (AW),
    .SLAVE_BASE    ({31'h000, 31'h100, 31'h200, 31'h000}),
    .SLAVE_MASK    ({31'h7FFF_F000, 31'h7FFF_FF00, 31'h7FFF_FF00, 31'h7FFF_FF00}),
    .TIMEOUT_CYCLES(TMO),
    .ERR_RDATA     (ERRD)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .m_valid  (m_valid),
    .m_write  (m_write),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_rdata  (m_rdata),
    .m_ready  (m_ready),
    .m_err    (m_err),
    .s_valid  (s_valid),
    .s_addr   (s_addr),
    .s_write  (s_write),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_rdata  (s_rdata),
    .s_ready  (s_ready),
    .err_clear(err_clear),
    .err_count(err_count),
    .err_addr (err_addr),
    .err_irq  (err_irq)
  );

  typedef struct {
    logic        wr;
    logic [30:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          exp_slv;    // -1: unmapped
    int          dly;        // 0: slave never answers
    logic        noise;      // unselected slaves hold ready high with junk data
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_svc;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  vec_t        vecs[8];
  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          err_model = 0;
  logic [30:0] err_addr_model = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input logic clr);
    exp_t       e;
    exp_t       got;
    int         cyc;
    int         svc;
    int         irqs;
    int         vcnt[NS];
    bit         done;
    bit         rdy;
    logic [3:0] sv_exp;
    e.err   = (v.exp_slv < 0) || (v.dly == 0);
    e.rdata = v.exp_rdata;
    e.lat   = v.exp_lat;
    sb.push_back(e);
    if (e.err) begin
      err_model      = clr ? 1 : ((err_model < 255) ? err_model + 1 : 255);
      err_addr_model = v.addr;
    end else if (clr) begin
      err_model = 0;
    end
    sv_exp = (v.exp_slv >= 0) ? 4'(1 << v.exp_slv) : 4'h0;
    for (int i = 0; i < NS; i++) vcnt[i] = 0;
    @(negedge sys_clk);
    m_valid = 1'b1; m_write = v.wr; m_addr = v.addr;
    m_wdata = v.wdata; m_wstrb = v.wstrb; err_clear = clr;
    s_ready = v.noise ? 4'hF : 4'h0;
    s_rdata = v.noise ? {4{32'hBAD0_0000}} : '0;
    cyc = 0; svc = 0; irqs = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge sys_clk);
      cyc++;
      m_valid = 1'b0; err_clear = 1'b0;
      if (s_valid != 4'h0) begin
        svc++;
        if (svc == 1) begin
          chk("s_valid_onehot", 32'(s_valid), 32'(sv_exp));
          chk("s_addr", 32'(s_addr), 32'(v.addr));
          chk("s_write", 32'(s_write), 32'(v.wr));
          chk("s_wdata", s_wdata, v.wdata);
          chk("s_wstrb", 32'(s_wstrb), 32'(v.wstrb));
        end
      end
      if (err_irq) irqs++;
      for (int i = 0; i < NS; i++) begin
        if (s_valid[i]) begin
          vcnt[i]++;
          rdy = (v.dly != 0) && (vcnt[i] == v.dly);
          s_ready[i] = rdy;
          s_rdata[i*32 +: 32] = rdy ? {4'hA, 4'(i), 8'h00, s_addr[15:0]} : 32'h0;
        end else begin
          vcnt[i] = 0;
          s_ready[i] = v.noise;
          s_rdata[i*32 +: 32] = v.noise ? 32'hBAD0_0000 : 32'h0;
        end
      end
      if (m_ready) begin
        done = 1;
        if (sb.size() == 0) begin
          chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
          got = sb.pop_front();
          chk("latency", 32'(cyc), 32'(got.lat));
          chk("m_err", 32'(m_err), 32'(got.err));
          chk("m_rdata", m_rdata, got.rdata);
          chk("err_count", 32'(err_count), 32'(err_model));
          chk("err_addr", 32'(err_addr), 32'(err_addr_model));
        end
      end
    end
    if (!done) chk("m_ready_timeout", 32'd0, 32'd1);
    s_ready = '0; s_rdata = '0;
    chk("s_valid_cycles", 32'(svc), 32'(v.exp_svc));
    chk("err_irq_pulses", 32'(irqs), e.err ? 32'd1 : 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_ready"}, 32'(m_ready), 32'd0);
    chk({tag, "_m_err"}, 32'(m_err), 32'd0);
    chk({tag, "_err_irq"}, 32'(err_irq), 32'd0);
    chk({tag, "_s_valid"}, 32'(s_valid), 32'd0);
    chk({tag, "_s_write"}, 32'(s_write), 32'd0);
    chk({tag, "_s_wstrb"}, 32'(s_wstrb), 32'd0);
    chk({tag, "_m_rdata"}, m_rdata, 32'd0);
    chk({tag, "_s_addr"}, 32'(s_addr), 32'd0);
    chk({tag, "_s_wdata"}, s_wdata, 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    chk({tag, "_err_addr"}, 32'(err_addr), 32'd0);
  endtask

  initial begin
    vec_t dec;
    vecs[0] = '{1'b0, 31'h104,       32'h0,         4'h0,    2,  3, 1'b0, 32'hA200_0104, 4, 3};
    vecs[1] = '{1'b1, 31'h004,       32'h1234_5678, 4'b0011, 0,  1, 1'b0, 32'hA000_0004, 2, 1};
    vecs[2] = '{1'b0, 31'h7000_0000, 32'h0,         4'h0,   -1,  0, 1'b0, 32'hDEAD_BEEF, 1, 0};
    vecs[3] = '{1'b0, 31'h204,       32'h0,         4'hF,    1,  0, 1'b0, 32'hDEAD_BEEF, 9, 8};
    vecs[4] = '{1'b0, 31'h400,       32'h55AA_55AA, 4'h0,    3,  2, 1'b0, 32'hA300_0400, 3, 2};
    vecs[5] = '{1'b0, 31'h010,       32'h0,         4'h0,    0,  1, 1'b1, 32'hA000_0010, 2, 1};
    vecs[6] = '{1'b1, 31'h30C,       32'hCAFE_F00D, 4'b1100, 3,  8, 1'b0, 32'hA300_030C, 9, 8};
    vecs[7] = '{1'b0, 31'h1FC,       32'h0,         4'h0,    2,  7, 1'b1, 32'hA200_01FC, 8, 7};

    rst_n = 1'b0; m_valid = 1'b0; m_write = 1'b0; m_addr = '0; m_wdata = '0;
    m_wstrb = '0; s_rdata = '0; s_ready = '0; err_clear = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], 1'b0);

    // Timeout followed by a stray ready from the abandoned slave.
    run_vec(vecs[3], 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      s_ready = 4'b0010; s_rdata = {4{32'h1111_2222}};
      chk("late_rdy_m_ready", 32'(m_ready), 32'd0);
      chk("late_rdy_s_valid", 32'(s_valid), 32'd0);
    end
    @(negedge sys_clk);
    s_ready = '0; s_rdata = '0;
    chk("late_rdy_err_count", 32'(err_count), 32'(err_model));
    chk("late_rdy_m_rdata", m_rdata, ERRD);
    run_vec(vecs[0], 1'b0);

    // Counter saturation, then clear coincident with an error, then a plain clear.
    dec = vecs[2];
    for (int i = 0; i < 300; i++) begin
      dec.addr = 31'h7000_0000 + 31'(i);
      run_vec(dec, 1'b0);
    end
    chk("sat_err_count", 32'(err_count), 32'd255);
    dec.addr = 31'h7ABC_0000;
    run_vec(dec, 1'b1);
    @(negedge sys_clk);
    err_clear = 1'b1;
    @(negedge sys_clk);
    err_clear = 1'b0;
    err_model = 0;
    chk("clear_err_count", 32'(err_count), 32'd0);

    // Reset in the middle of an ACCESS phase.
    dec = vecs[2];
    run_vec(dec, 1'b0);
    @(negedge sys_clk);
    m_valid = 1'b1; m_write = 1'b1; m_addr = 31'h204; m_wdata = 32'h7777_8888; m_wstrb = 4'hF;
    @(negedge sys_clk);
    m_valid = 1'b0;
    chk("pre_rst_s_valid", 32'(s_valid), 32'h2);
    @(negedge sys_clk);
    chk("pre_rst_m_ready", 32'(m_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge sys_clk);
    chk_all_zero("mid_rst");
    rst_n = 1'b1;
    err_model = 0; err_addr_model = '0;
    run_vec(vecs[0], 1'b0);
    run_vec(vecs[1], 1'b0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

endmodule
